// File: rtl/lsu_req.sv
// RV32 load/store initiator: effective address, funct3/alignment/range checks, one-cycle RAM access, writeback or fault.
// Fault 1, store 2, load 3 cycles after accept; req_ready is high only in IDLE, so execute stalls while an op is in flight.
module lsu_req #(
  parameter int MEM_ADDR_W = 12,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_base,
  input  logic [XLEN-1:0]       req_imm,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [4:0]            req_rd,
  input  logic                  flush,
  output logic                  mem_en_write,
  output logic                  mem_en_read,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_din,
  output logic [1:0]            mem_size,
  output logic                  mem_unsigned,
  input  logic [XLEN-1:0]       mem_dout,
  output logic                  resp_valid,
  output logic                  resp_we,
  output logic [4:0]            resp_rd,
  output logic [XLEN-1:0]       resp_data,
  output logic                  exc_valid,
  output logic [1:0]            exc_cause,
  output logic [XLEN-1:0]       exc_addr
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  logic [2:0]      state;
  logic [XLEN-1:0] ea_q;
  logic            store_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] din_q;
  logic [XLEN-1:0] data_q;
  logic [1:0]      cause_q;
  logic            kill_q;

  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] wdata_lane;
  logic            illegal;
  logic            misaligned;
  logic            out_of_range;
  logic [1:0]      cause;
  logic            accept;

  assign ea     = req_base + req_imm;
  assign accept = req_valid && (state == S_IDLE);

  always_comb begin
    if (req_store)
      illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
  end

  assign misaligned   = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
  assign out_of_range = (ea[XLEN-1:MEM_ADDR_W] != '0);

  // Later assignments override earlier ones, giving funct3 > alignment > range priority.
  always_comb begin
    cause = 2'b00;
    if (out_of_range) cause = 2'b10;
    if (misaligned)   cause = 2'b01;
    if (illegal)      cause = 2'b11;
  end

  always_comb begin
    wdata_lane = req_wdata;
    if (req_funct3[1:0] != 2'b10)
      wdata_lane = req_wdata << {ea[1:0], 3'b000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ea_q    <= '0;
      store_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rd_q    <= 5'd0;
      din_q   <= '0;
      data_q  <= '0;
      cause_q <= 2'b00;
      kill_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          kill_q <= 1'b0;
          if (accept) begin
            ea_q    <= ea;
            store_q <= req_store;
            size_q  <= req_funct3[1:0];
            uns_q   <= req_funct3[2];
            rd_q    <= req_rd;
            din_q   <= wdata_lane;
            data_q  <= '0;
            cause_q <= cause;
            state   <= (cause != 2'b00) ? S_FAULT : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush) kill_q <= 1'b1;
          state <= store_q ? S_RESP : S_CAPTURE;
        end
        S_CAPTURE: begin
          if (flush) kill_q <= 1'b1;
          data_q <= mem_dout;
          state  <= S_RESP;
        end
        S_RESP, S_FAULT: begin
          kill_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes decode straight from the state register, so async reset drops them immediately.
  assign req_ready    = (state == S_IDLE);
  assign mem_en_read  = (state == S_ISSUE) && !store_q;
  assign mem_en_write = (state == S_ISSUE) && store_q;
  assign mem_addr     = ea_q[MEM_ADDR_W-1:0];
  assign mem_din      = din_q;
  assign mem_size     = size_q;
  assign mem_unsigned = uns_q;

  assign resp_valid   = (state == S_RESP) && !kill_q;
  assign resp_we      = resp_valid && !store_q;
  assign resp_rd      = rd_q;
  assign resp_data    = data_q;

  assign exc_valid    = (state == S_FAULT) && !kill_q;
  assign exc_cause    = cause_q;
  assign exc_addr     = ea_q;

endmodule
